// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory request arbiter.
package mem_arb_pkg;

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} arb_state_e;

  localparam int MAX_REQ = 8;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // First set bit scanning upward from last+1, wrapping at n; returns last if none set.
  function automatic int rr_pick(input logic [MAX_REQ-1:0] vld, input int last, input int n);
    int         pick;
    logic       found;
    logic [2:0] idx;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      idx = 3'((last + k) % n);
      if (k <= n && !found && vld[idx]) begin
        pick  = int'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mem_rd_tag_pipe.sv
// Fixed-latency {vld, id} shift register tracking in-flight reads.
module mem_rd_tag_pipe #(
  parameter int DEPTH = 2,
  parameter int ID_W  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_vld,
  input  logic [ID_W-1:0] push_id,
  output logic            tail_vld,
  output logic [ID_W-1:0] tail_id
);

  logic [DEPTH-1:0]           vld_pipe;
  logic [DEPTH-1:0][ID_W-1:0] id_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      vld_pipe[0] <= push_vld;
      id_pipe[0]  <= push_id;
      for (int i = 1; i < DEPTH; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        id_pipe[i]  <= id_pipe[i-1];
      end
    end
  end

  assign tail_vld = vld_pipe[DEPTH-1];
  assign tail_id  = id_pipe[DEPTH-1];

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter with bounded burst locking in front of a single memory port;
// routes fixed-latency read data back to the issuing requester.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int RD_LATENCY = 2,
  parameter int MAX_BURST  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_wr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_WIDTH-1:0]          rsp_data,
  output logic                           mem_valid,
  output logic                           mem_wr,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  output logic [DATA_WIDTH-1:0]          mem_wdata,
  input  logic                           mem_ready,
  input  logic [DATA_WIDTH-1:0]          mem_rdata
);

  localparam int ID_W  = id_w(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e          state;
  logic [ID_W-1:0]     owner, last_grant, grant_id, tail_id;
  logic [CNT_W-1:0]    burst_cnt;
  logic [MAX_REQ-1:0]  vld_ext;
  logic                locked, accept, rd_push, tail_vld;

  always_comb begin
    vld_ext                = '0;
    vld_ext[NUM_REQ-1:0]   = req_valid;
    // An owner that drops valid is arbitrated as IDLE in the same cycle.
    locked    = (state == LOCK) && req_valid[owner];
    grant_id  = locked ? owner : ID_W'(rr_pick(vld_ext, int'(last_grant), NUM_REQ));
    mem_valid = |req_valid;
    accept    = mem_valid && mem_ready;
    mem_wr    = mem_valid && req_wr[grant_id];
    mem_addr  = mem_valid ? req_addr[grant_id*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    mem_wdata = mem_valid ? req_wdata[grant_id*DATA_WIDTH +: DATA_WIDTH] : '0;
    req_ready = '0;
    if (accept) req_ready[grant_id] = 1'b1;
    rd_push   = accept && !req_wr[grant_id];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
      burst_cnt  <= '0;
    end else if (accept) begin
      if (locked) begin
        burst_cnt <= burst_cnt + 1'b1;
        if (burst_cnt == CNT_W'(MAX_BURST - 1)) state <= IDLE;
      end else begin
        owner      <= grant_id;
        last_grant <= grant_id;
        burst_cnt  <= CNT_W'(1);
        state      <= (MAX_BURST > 1) ? LOCK : IDLE;
      end
    end else if (state == LOCK && !req_valid[owner]) begin
      state <= IDLE;
    end
  end

  mem_rd_tag_pipe #(
    .DEPTH (RD_LATENCY),
    .ID_W  (ID_W)
  ) u_tag_pipe (
    .clk      (clk),
    .rst      (rst),
    .push_vld (rd_push),
    .push_id  (grant_id),
    .tail_vld (tail_vld),
    .tail_id  (tail_id)
  );

  // Gated by rst so a read landing in the reset cycle is dropped too.
  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    if (tail_vld && !rst) begin
      rsp_valid[tail_id] = 1'b1;
      rsp_data           = mem_rdata;
    end
  end

endmodule
